beehive_vr_prepare_ok_tx: RTL and testbench

//  Replica-side transmitter for the VR PrepareOK message. Accepts one
//  {view, opnum, rep_index} request per message. Builds the 13-byte beehive

---
 rtl/beehive_vr_prepare_ok_tx.sv | 93 +++++++++
 tb/tb_beehive_vr_prepare_ok_tx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/beehive_vr_prepare_ok_tx.sv
// Replica-side PrepareOK transmitter: latches {view, opnum, rep_index}, builds the
// 37-byte beehive + prepare_ok header and streams it out MSB-first in DATA_W beats.
module beehive_vr_prepare_ok_tx #(
   parameter int          DATA_W     = 256,
   parameter logic [31:0] FRAG_MAGIC = 32'h20050318,
   parameter int          CNT_W      = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_val,
   input  logic [63:0]               req_view,
   input  logic [63:0]               req_opnum,
   input  logic [63:0]               req_rep_index,
   output logic                      req_rdy,
   output logic                      tx_val,
   output logic [DATA_W-1:0]         tx_data,
   output logic                      tx_last,
   output logic [$clog2(DATA_W/8):0] tx_padbytes,
   input  logic                      tx_rdy,
   output logic [CNT_W-1:0]          msgs_sent
);
   localparam int FRAME_W = 296;
   localparam int NBEATS  = (FRAME_W + DATA_W - 1) / DATA_W;
   localparam int TOT_W   = NBEATS * DATA_W;
   localparam int PAD     = TOT_W / 8 - FRAME_W / 8;
   localparam int PAD_W   = $clog2(DATA_W/8) + 1;
   localparam int BW      = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   typedef struct packed {
      logic [63:0] view;
      logic [63:0] opnum;
      logic [63:0] rep_index;
   } prep_ok_t;

   prep_ok_t           req;
   logic [FRAME_W-1:0] frame;
   logic [0:0]         state;
   logic [BW-1:0]      beat_cnt;
   logic [TOT_W-1:0]   frame_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               accept;
   logic               beat_done;

   assign req   = '{view: req_view, opnum: req_opnum, rep_index: req_rep_index};
   assign frame = {FRAG_MAGIC, 8'd5, 64'd24, req};

   // Outputs decode straight from state so an async reset drops tx_val at once.
   assign req_rdy     = (state == IDLE);
   assign tx_val      = (state == SEND);
   assign tx_last     = tx_val & (beat_cnt == LAST_BEAT);
   assign tx_data     = tx_val ? frame_q[TOT_W-1 -: DATA_W] : '0;
   assign tx_padbytes = tx_last ? PAD_W'(PAD) : '0;
   assign msgs_sent   = cnt_q;

   assign accept    = req_val & req_rdy;
   assign beat_done = tx_val & tx_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         beat_cnt <= '0;
         frame_q  <= '0;
         cnt_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  frame_q  <= {frame, {(TOT_W-FRAME_W){1'b0}}};
                  beat_cnt <= '0;
                  state    <= SEND;
               end
            end
            default: begin
               if (beat_done) begin
                  if (tx_last) begin
                     cnt_q <= cnt_q + 1'b1;
                     state <= IDLE;
                  end else begin
                     // Current beat always sits in the top DATA_W bits.
                     frame_q  <= frame_q << DATA_W;
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_beehive_vr_prepare_ok_tx.sv
// Scoreboard bench: a 128-bit instance (3 beats, 4-bit counter) and a 512-bit instance (1 beat).
module tb_beehive_vr_prepare_ok_tx;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [63:0]  view = '0, opnum = '0, rep = '0;

   logic         req_val_a = 1'b0, rdy_a = 1'b0, req_rdy_a, tx_val_a, tx_last_a;
   logic [127:0] tx_data_a;
   logic [4:0]   tx_pad_a;
   logic [3:0]   msgs_a;

   logic         req_val_b = 1'b0, rdy_b = 1'b1, req_rdy_b, tx_val_b, tx_last_b;
   logic [511:0] tx_data_b;
   logic [6:0]   tx_pad_b;
   logic [31:0]  msgs_b;

   beehive_vr_prepare_ok_tx #(.DATA_W(128), .CNT_W(4)) u_a (
      .clk(clk), .rst_n(rst_n), .req_val(req_val_a), .req_view(view), .req_opnum(opnum),
      .req_rep_index(rep), .req_rdy(req_rdy_a), .tx_val(tx_val_a), .tx_data(tx_data_a),
      .tx_last(tx_last_a), .tx_padbytes(tx_pad_a), .tx_rdy(rdy_a), .msgs_sent(msgs_a));

   beehive_vr_prepare_ok_tx #(.DATA_W(512)) u_b (
      .clk(clk), .rst_n(rst_n), .req_val(req_val_b), .req_view(view), .req_opnum(opnum),
      .req_rep_index(rep), .req_rdy(req_rdy_b), .tx_val(tx_val_b), .tx_data(tx_data_b),
      .tx_last(tx_last_b), .tx_padbytes(tx_pad_b), .tx_rdy(rdy_b), .msgs_sent(msgs_b));

   initial forever #5 clk = ~clk;

   typedef struct packed {
      logic [127:0] d;
      logic         last;
      logic [4:0]   pad;
   } beat_a_t;

   beat_a_t    qa[$];
   logic [3:0] exp_cnt_a = '0;
   int         vecs = 0;
   int         errs = 0;

   function automatic logic [295:0] mk_frame(input logic [63:0] v, input logic [63:0] o,
                                             input logic [63:0] r);
      return {32'h20050318, 8'h05, 64'd24, v, o, r};
   endfunction

   task automatic push_a(input logic [63:0] v, input logic [63:0] o, input logic [63:0] r);
      logic [383:0] f;
      f = {mk_frame(v, o, r), 88'b0};
      for (int i = 0; i < 3; i++)
         qa.push_back('{d: f[383-128*i -: 128], last: (i == 2), pad: (i == 2) ? 5'd11 : 5'd0});
   endtask

   // Presents a request at a negedge; it is accepted on the following posedge.
   task automatic send_a(input logic [63:0] v, input logic [63:0] o, input logic [63:0] r,
                         input bit hold);
      int t;
      t = 0;
      @(negedge clk);
      while (!req_rdy_a && t < 50) begin
         @(negedge clk);
         t++;
      end
      vecs++;
      if (req_rdy_a !== 1'b1) begin
         errs++;
         $display("FAIL send_a_rdy_timeout: req_rdy=%b required 1", req_rdy_a);
      end
      view = v; opnum = o; rep = r; req_val_a = 1'b1;
      @(posedge clk);
      push_a(v, o, r);
      #1;
      if (!hold) req_val_a = 1'b0;
      vecs++;
      if (tx_val_a !== 1'b1) begin
         errs++;
         $display("FAIL first_beat_latency: tx_val=%b required 1", tx_val_a);
      end
   endtask

   // Drains the scoreboard; beat index stall_beat sees tx_rdy low for stall_cyc cycles.
   task automatic drain_a(input int stall_beat, input int stall_cyc);
      beat_a_t h;
      int      cyc, idx, stalls;
      cyc = 0; idx = 0; stalls = 0;
      if (idx == stall_beat && stalls < stall_cyc) begin rdy_a = 1'b0; stalls++; end
      else rdy_a = 1'b1;
      while (qa.size() > 0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (tx_val_a) begin
            h = qa[0];
            vecs++;
            if ({tx_data_a, tx_last_a, tx_pad_a} !== {h.d, h.last, h.pad} || req_rdy_a !== 1'b0) begin
               errs++;
               $display("FAIL beat%0d: data=%h last=%b pad=%0d rdy=%b required data=%h last=%b pad=%0d rdy=0",
                        idx, tx_data_a, tx_last_a, tx_pad_a, req_rdy_a, h.d, h.last, h.pad);
            end
            if (rdy_a) begin
               void'(qa.pop_front());
               idx++;
               if (h.last) exp_cnt_a = exp_cnt_a + 1'b1;
            end
         end
         @(posedge clk);
         #1;
         if (idx == stall_beat && stalls < stall_cyc) begin rdy_a = 1'b0; stalls++; end
         else rdy_a = 1'b1;
      end
      vecs++;
      if (qa.size() != 0 || tx_val_a !== 1'b0 || req_rdy_a !== 1'b1 || msgs_a !== exp_cnt_a) begin
         errs++;
         $display("FAIL msg_done: left=%0d tx_val=%b req_rdy=%b msgs=%0d required left=0 tx_val=0 req_rdy=1 msgs=%0d",
                  qa.size(), tx_val_a, req_rdy_a, msgs_a, exp_cnt_a);
         qa.delete();
      end
   endtask

   task automatic test_reset;
      #1;
      vecs++;
      if (tx_val_a !== 1'b0 || tx_last_a !== 1'b0 || tx_data_a !== '0 || tx_pad_a !== '0 ||
          msgs_a !== '0 || tx_val_b !== 1'b0 || tx_data_b !== '0 || msgs_b !== '0) begin
         errs++;
         $display("FAIL reset_outputs: val=%b last=%b pad=%0d msgs=%0d val_b=%b msgs_b=%0d required all 0",
                  tx_val_a, tx_last_a, tx_pad_a, msgs_a, tx_val_b, msgs_b);
      end
      #21 rst_n = 1'b1;
      @(negedge clk);
      vecs++;
      if (req_rdy_a !== 1'b1 || req_rdy_b !== 1'b1) begin
         errs++;
         $display("FAIL reset_req_rdy: a=%b b=%b required 1", req_rdy_a, req_rdy_b);
      end
   endtask

   task automatic test_single_beat_512;
      logic [511:0] exp;
      exp = {32'h20050318, 8'h05, 64'h18, 64'd1, 64'd7, 64'd2, 216'b0};
      @(negedge clk);
      view = 64'd1; opnum = 64'd7; rep = 64'd2; req_val_b = 1'b1;
      @(posedge clk); #1 req_val_b = 1'b0;
      @(negedge clk);
      vecs++;
      if (tx_val_b !== 1'b1 || tx_last_b !== 1'b1 || tx_pad_b !== 7'd27 || tx_data_b !== exp) begin
         errs++;
         $display("FAIL beat_512: val=%b last=%b pad=%0d data=%h required val=1 last=1 pad=27 data=%h",
                  tx_val_b, tx_last_b, tx_pad_b, tx_data_b, exp);
      end
      @(negedge clk);
      vecs++;
      if (msgs_b !== 32'd1 || tx_val_b !== 1'b0) begin
         errs++;
         $display("FAIL msgs_512: msgs=%0d val=%b required msgs=1 val=0", msgs_b, tx_val_b);
      end
   endtask

   task automatic test_three_beats;
      send_a(64'd1, 64'd7, 64'd2, 1'b0);
      drain_a(-1, 0);
      send_a(64'hdead_beef_0123_4567, 64'hffff_ffff_ffff_fffe, 64'h8000_0000_0000_0001, 1'b0);
      drain_a(-1, 0);
   endtask

   task automatic test_backpressure;
      send_a(64'h1111, 64'h2222, 64'h3333, 1'b0);
      drain_a(1, 5);
      send_a(64'ha5a5, 64'h5a5a, 64'h0f0f, 1'b0);
      drain_a(2, 3);
   endtask

   task automatic test_input_capture;
      send_a(64'd10, 64'd20, 64'd30, 1'b1);
      view = ~64'd0; opnum = 64'h5555; rep = 64'h7777;
      drain_a(-1, 0);
      view = 64'd40; opnum = 64'd50; rep = 64'd60;
      push_a(64'd40, 64'd50, 64'd60);
      @(posedge clk); #1 req_val_a = 1'b0;
      drain_a(-1, 0);
   endtask

   task automatic test_reset_mid_message;
      send_a(64'd3, 64'd4, 64'd5, 1'b0);
      rdy_a = 1'b1;
      @(negedge clk);
      vecs++;
      if (tx_data_a !== qa[0].d) begin
         errs++;
         $display("FAIL rst_beat0: data=%h required %h", tx_data_a, qa[0].d);
      end
      void'(qa.pop_front());
      @(posedge clk); #2;
      vecs++;
      if (tx_val_a !== 1'b1 || tx_data_a !== qa[0].d) begin
         errs++;
         $display("FAIL rst_beat1: val=%b data=%h required val=1 data=%h", tx_val_a, tx_data_a, qa[0].d);
      end
      rst_n = 1'b0;
      #1;
      qa.delete();
      exp_cnt_a = '0;
      vecs++;
      if (tx_val_a !== 1'b0 || tx_last_a !== 1'b0 || msgs_a !== exp_cnt_a) begin
         errs++;
         $display("FAIL rst_async: val=%b last=%b msgs=%0d required val=0 last=0 msgs=0",
                  tx_val_a, tx_last_a, msgs_a);
      end
      @(negedge clk); rst_n = 1'b1;
      send_a(64'd9, 64'd8, 64'd7, 1'b0);
      drain_a(-1, 0);
   endtask

   task automatic test_counter_wrap;
      while (exp_cnt_a != 4'hf) begin
         send_a(64'(exp_cnt_a), 64'd1, 64'd0, 1'b0);
         drain_a(-1, 0);
      end
      send_a(64'd99, 64'd98, 64'd97, 1'b0);
      drain_a(-1, 0);
      vecs++;
      if (msgs_a !== 4'd0) begin
         errs++;
         $display("FAIL counter_wrap: msgs=%0d required 0", msgs_a);
      end
   endtask

   initial begin
      test_reset();
      test_single_beat_512();
      test_three_beats();
      test_backpressure();
      test_input_capture();
      test_reset_mid_message();
      test_counter_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
